// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter_if
// Description : Writeback request ports, register-file write strobe and hazard
//               query signals of the register-file write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             wb0_valid;
    logic [4:0]       wb0_rd;
    logic [XLEN-1:0]  wb0_data;
    logic             wb0_ready;
    logic             wb1_valid;
    logic [4:0]       wb1_rd;
    logic [XLEN-1:0]  wb1_data;
    logic             wb1_ready;
    logic             wr_en;
    logic [4:0]       wr_rd;
    logic [XLEN-1:0]  wr_data;
    logic [4:0]       q_rs1;
    logic [4:0]       q_rs2;
    logic             hz_rs1;
    logic             hz_rs2;
    logic [CNT_W-1:0] contention_cnt;

    modport master (
        output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
        output q_rs1, q_rs2,
        input  wb0_ready, wb1_ready, wr_en, wr_rd, wr_data,
        input  hz_rs1, hz_rs2, contention_cnt
    );

    modport slave (
        input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
        input  q_rs1, q_rs2,
        output wb0_ready, wb1_ready, wr_en, wr_rd, wr_data,
        output hz_rs1, hz_rs2, contention_cnt
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Two one-entry writeback buffers sharing the register file's
//               single write port. Define REGFILE_ARB_RR_EN for round-robin
//               tie-break; otherwise port 1 (load) always wins ties.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    regfile_write_arbiter_if.slave bus
);
    localparam logic [4:0]       c_X0      = 5'd0;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic             r_full0, r_full1;
    logic [4:0]       r_rd0, r_rd1;
    logic [XLEN-1:0]  r_data0, r_data1;
    logic             r_wr_en;
    logic [4:0]       r_wr_rd;
    logic [XLEN-1:0]  r_wr_data;
    logic [CNT_W-1:0] r_cnt;

    logic w_comp0, w_comp1, w_tie;
    logic w_grant0, w_grant1;
    logic w_drain0, w_drain1;
    logic w_ready0, w_ready1;
    logic w_load0, w_load1;

    // x0 writes never compete; they simply drain below
    assign w_comp0 = r_full0 && (r_rd0 != c_X0);
    assign w_comp1 = r_full1 && (r_rd1 != c_X0);
    assign w_tie   = w_comp0 && w_comp1;

`ifdef REGFILE_ARB_RR_EN
    logic r_rr_p1;  // set when port 1 owns the next tie

    assign w_grant1 = w_comp1 && (!w_comp0 || r_rr_p1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_p1 <= 1'b0;
        end else if (w_tie) begin
            r_rr_p1 <= w_grant0;
        end
    end
`else
    assign w_grant1 = w_comp1;
`endif

    assign w_grant0 = w_comp0 && !w_grant1;
    assign w_drain0 = r_full0 && ((r_rd0 == c_X0) || w_grant0);
    assign w_drain1 = r_full1 && ((r_rd1 == c_X0) || w_grant1);
    assign w_ready0 = !r_full0 || w_drain0;
    assign w_ready1 = !r_full1 || w_drain1;
    assign w_load0  = bus.wb0_valid && w_ready0;
    assign w_load1  = bus.wb1_valid && w_ready1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full0 <= 1'b0;
            r_rd0   <= '0;
            r_data0 <= '0;
            r_full1 <= 1'b0;
            r_rd1   <= '0;
            r_data1 <= '0;
        end else begin
            if (w_load0) begin
                r_full0 <= 1'b1;
                r_rd0   <= bus.wb0_rd;
                r_data0 <= bus.wb0_data;
            end else if (w_drain0) begin
                r_full0 <= 1'b0;
            end
            if (w_load1) begin
                r_full1 <= 1'b1;
                r_rd1   <= bus.wb1_rd;
                r_data1 <= bus.wb1_data;
            end else if (w_drain1) begin
                r_full1 <= 1'b0;
            end
        end
    end

    // Address and data hold between strobes; only wr_en is pulsed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_rd   <= '0;
            r_wr_data <= '0;
            r_cnt     <= '0;
        end else begin
            r_wr_en <= w_grant0 || w_grant1;
            if (w_grant1) begin
                r_wr_rd   <= r_rd1;
                r_wr_data <= r_data1;
            end else if (w_grant0) begin
                r_wr_rd   <= r_rd0;
                r_wr_data <= r_data0;
            end
            if (w_tie && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.wb0_ready      = w_ready0;
    assign bus.wb1_ready      = w_ready1;
    assign bus.wr_en          = r_wr_en;
    assign bus.wr_rd          = r_wr_rd;
    assign bus.wr_data        = r_wr_data;
    assign bus.contention_cnt = r_cnt;

    assign bus.hz_rs1 = (bus.q_rs1 != c_X0) &&
                        ((r_full0 && (r_rd0 == bus.q_rs1)) ||
                         (r_full1 && (r_rd1 == bus.q_rs1)) ||
                         (r_wr_en && (r_wr_rd == bus.q_rs1)));
    assign bus.hz_rs2 = (bus.q_rs2 != c_X0) &&
                        ((r_full0 && (r_rd0 == bus.q_rs2)) ||
                         (r_full1 && (r_rd1 == bus.q_rs2)) ||
                         (r_wr_en && (r_wr_rd == bus.q_rs2)));
endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Self-checking bench; expected strobes are queued as requests
//               are driven and compared whenever wr_en is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    wr_t  exp_q[$];

    regfile_write_arbiter_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    regfile_write_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Strobe monitor: each strobe cycle must match the oldest queued write
    always @(negedge clk) begin
        if (!rst && bus.wr_en) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_strobe", 64'd1, 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_val("strobe_rd", {59'd0, bus.wr_rd}, {59'd0, e.rd});
                check_val("strobe_data", {32'd0, bus.wr_data}, {32'd0, e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb0_valid = 1'b0; bus.wb0_rd = '0; bus.wb0_data = '0;
        bus.wb1_valid = 1'b0; bus.wb1_rd = '0; bus.wb1_data = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_wr(input logic [4:0] rd, input logic [XLEN-1:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Assumes a freshly reset arbiter; k cycles of both ports offering a write
    task automatic run_tie(input int k, input logic [XLEN-1:0] da, input logic [XLEN-1:0] db);
        int exp_cnt;
`ifdef REGFILE_ARB_RR_EN
        for (int i = 0; i <= k; i++) begin
            if (i % 2 == 0) push_wr(5'd3, da);
            else            push_wr(5'd4, db);
        end
`else
        for (int i = 0; i < k; i++) push_wr(5'd4, db);
        push_wr(5'd3, da);
`endif
        bus.wb0_valid = 1'b1; bus.wb0_rd = 5'd3; bus.wb0_data = da;
        bus.wb1_valid = 1'b1; bus.wb1_rd = 5'd4; bus.wb1_data = db;
        for (int i = 1; i <= k; i++) begin
            tick();
`ifndef REGFILE_ARB_RR_EN
            check_val("tie_wb0_ready", {63'd0, bus.wb0_ready}, 64'd0);
`endif
            if (i == 2) check_val("tie_cnt_first", {60'd0, bus.contention_cnt}, 64'd1);
        end
        idle_inputs();
        tick();
        exp_cnt = (k > 15) ? 15 : k;
        check_val("tie_cnt", {60'd0, bus.contention_cnt}, exp_cnt);
        tick();
        tick();
        check_val("tie_cnt_hold", {60'd0, bus.contention_cnt}, exp_cnt);
        check_val("tie_drained", exp_q.size(), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        idle_inputs();
        bus.q_rs1 = 5'd0;
        bus.q_rs2 = 5'd0;
        #12;
        check_val("rst_wr_en", {63'd0, bus.wr_en}, 64'd0);
        check_val("rst_wr_rd", {59'd0, bus.wr_rd}, 64'd0);
        check_val("rst_wr_data", {32'd0, bus.wr_data}, 64'd0);
        check_val("rst_cnt", {60'd0, bus.contention_cnt}, 64'd0);
        check_val("rst_ready0", {63'd0, bus.wb0_ready}, 64'd1);
        check_val("rst_ready1", {63'd0, bus.wb1_ready}, 64'd1);
        apply_reset();

        // Single write
        bus.q_rs1 = 5'd5;
        bus.wb0_valid = 1'b1; bus.wb0_rd = 5'd5; bus.wb0_data = 32'hDEADBEEF;
        push_wr(5'd5, 32'hDEADBEEF);
        check_val("single_hz_before", {63'd0, bus.hz_rs1}, 64'd0);
        tick();
        idle_inputs();
        check_val("single_hz_e1", {63'd0, bus.hz_rs1}, 64'd1);
        check_val("single_wr_en_e1", {63'd0, bus.wr_en}, 64'd0);
        tick();
        check_val("single_wr_en_e2", {63'd0, bus.wr_en}, 64'd1);
        check_val("single_hz_e2", {63'd0, bus.hz_rs1}, 64'd1);
        tick();
        check_val("single_wr_en_e3", {63'd0, bus.wr_en}, 64'd0);
        check_val("single_hz_e3", {63'd0, bus.hz_rs1}, 64'd0);

        // x0 drop
        bus.q_rs1 = 5'd0;
        bus.wb1_valid = 1'b1; bus.wb1_rd = 5'd0; bus.wb1_data = 32'h1234;
        tick();
        idle_inputs();
        check_val("x0_hz", {63'd0, bus.hz_rs1}, 64'd0);
        check_val("x0_wr_en", {63'd0, bus.wr_en}, 64'd0);
        tick();
        check_val("x0_ready1", {63'd0, bus.wb1_ready}, 64'd1);
        check_val("x0_wr_en_late", {63'd0, bus.wr_en}, 64'd0);

        // Streaming on port 0
        for (int i = 1; i <= 4; i++) begin
            bus.wb0_valid = 1'b1; bus.wb0_rd = 5'(i); bus.wb0_data = 32'h100 + 32'(i);
            push_wr(5'(i), 32'h100 + 32'(i));
            check_val("stream_ready0", {63'd0, bus.wb0_ready}, 64'd1);
            tick();
        end
        idle_inputs();
        tick(); tick(); tick();
        check_val("stream_drained", exp_q.size(), 64'd0);

        // Tie
        apply_reset();
        run_tie(6, 32'hAAAA0003, 32'hBBBB0004);

        // Reset mid-flight
        apply_reset();
        bus.q_rs1 = 5'd7;
        bus.q_rs2 = 5'd8;
        bus.wb0_valid = 1'b1; bus.wb0_rd = 5'd7; bus.wb0_data = 32'h77;
        bus.wb1_valid = 1'b1; bus.wb1_rd = 5'd8; bus.wb1_data = 32'h88;
        tick();
`ifdef REGFILE_ARB_RR_EN
        push_wr(5'd7, 32'h77);
`else
        push_wr(5'd8, 32'h88);
`endif
        tick();
        idle_inputs();
        check_val("mid_wr_en", {63'd0, bus.wr_en}, 64'd1);
        check_val("mid_hz1", {63'd0, bus.hz_rs1}, 64'd1);
        check_val("mid_hz2", {63'd0, bus.hz_rs2}, 64'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("mid_rst_wr_en", {63'd0, bus.wr_en}, 64'd0);
        check_val("mid_rst_ready0", {63'd0, bus.wb0_ready}, 64'd1);
        check_val("mid_rst_ready1", {63'd0, bus.wb1_ready}, 64'd1);
        check_val("mid_rst_hz1", {63'd0, bus.hz_rs1}, 64'd0);
        check_val("mid_rst_cnt", {60'd0, bus.contention_cnt}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        check_val("mid_no_strobe", {63'd0, bus.wr_en}, 64'd0);
        check_val("mid_queue", exp_q.size(), 64'd0);

        // Saturation of a 4-bit counter
        bus.q_rs1 = 5'd0;
        bus.q_rs2 = 5'd0;
        apply_reset();
        run_tie(20, 32'hCAFE0003, 32'hF00D0004);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

- Shares the register file's single write port between two writeback requesters in the multi-cycle core: port 0 (ALU/execute result) and port 1 (load data from memory).
- Each requester hands off through a valid/ready handshake into a one-entry holding buffer.
- Each cycle the arbiter drains at most one buffer into a registered write strobe that drives the register file's `write_register`/`rd`/`rdv` inputs.
- It also reports read-after-write hazards for the decoder's source registers while writes are still in flight.

## Interface
Parameters:
- `XLEN`, 32, data width of write values.
- `CNT_W`, 16, width of the contention counter.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `wb0_valid` in 1: port 0 request.
- `wb0_rd` in 5: port 0 destination.
- `wb0_data` in XLEN: port 0 value.
- `wb0_ready` out 1: port 0 may hand off.
- `wb1_valid`, `wb1_rd`, `wb1_data`, `wb1_ready`: same set for port 1.
- `wr_en` out 1: write strobe to register file (`write_register`).
- `wr_rd` out 5: write address to register file.
- `wr_data` out XLEN: write value to register file.
- `q_rs1`, `q_rs2` in 5: decoder source registers to check.
- `hz_rs1`, `hz_rs2` out 1: pending write targets that source.
- `contention_cnt` out CNT_W: saturating count of conflict cycles.

## Operation
- Buffer per port: `full_i`, `rd_i`, `data_i`. Handshake on port i occurs when `wbi_valid && wbi_ready` at a posedge; the buffer loads rd/data and sets `full_i`.
- `wbi_ready = !full_i || drain_i`, where `drain_i` means buffer i empties this edge. A drained buffer may be refilled on the same edge. `ready` never depends on `valid`.
- x0 writes: a full buffer with `rd_i == 0` drains unconditionally and does not compete for the port. No strobe is issued for it.
- Competing buffers are full buffers with `rd_i != 0`.
  - One competitor: it is granted.
  - Two competitors: tie-break per Configuration; the loser holds its contents unchanged.
- Grant: the winner drains. At the edge, `wr_en <= 1`, `wr_rd <= rd_win`, `wr_data <= data_win`. With no grant, `wr_en <= 0`; `wr_rd` and `wr_data` hold their values.
- Same-register ordering: when both buffers target the same rd, grant order alone decides which value the register file ends with. Upstream sequencing guarantees the two ports never hold conflicting writes to one rd out of program order.
- Hazard flags are combinational from state only:
  - `hz_rsN = (q_rsN != 0) && ((full0 && rd0 == q_rsN) || (full1 && rd1 == q_rsN) || (wr_en && wr_rd == q_rsN))`.
  - Registers with `rd == 0` never flag.
- Contention counter: `contention_cnt` increments by 1 at each edge where both buffers compete. It saturates at all-ones and never wraps.

## Timing
- Reset values, forced asynchronously while `rst` is high:
  - `full0 = full1 = 0`, `wr_en = 0`, `wr_rd = 0`, `wr_data = 0`, `contention_cnt = 0`.
  - Round-robin pointer is set so port 0 wins the first tie.
  - Outputs during reset: `wb0_ready = wb1_ready = 1`, `hz_rs1 = hz_rs2 = 0`.
- Reset mid-operation discards both buffered writes and any pending strobe. No write reaches the register file after `rst` rises.
- Latency: a handshake at edge T with no contention produces `wr_en = 1` for the cycle between edges T+1 and T+2. The register file samples it within that cycle.
- `wr_en` is asserted for exactly one cycle per granted write. Back-to-back grants produce consecutive strobe cycles.
- Sustained throughput is one write per cycle total across both ports. A single port streams at one handshake per cycle when uncontended.

## Configuration
- `REGFILE_ARB_RR_EN` defined: round-robin tie-break. The port not granted on the most recent tie wins the next tie. Only tie cycles update the pointer.
- Not defined: fixed priority. Port 1 (load) always wins ties. The pointer logic is absent.
- Everything else is identical in both builds, including the contention counter.

## Test plan
- Single write: reset, then `wb0` with rd=5, data=0xDEADBEEF, handshake at edge 1.
  - Edge 2: `wr_en = 1`, `wr_rd = 5`, `wr_data = 0xDEADBEEF`.
  - Edge 3: `wr_en = 0`.
  - `hz_rs1 = 1` for `q_rs1 = 5` from edge 1 until edge 3.
- Tie, round-robin build: both ports hold valid every cycle, rd 3 and 4. Grants alternate 3, 4, 3, 4, and `contention_cnt` increments every cycle.
  - Fixed build: only rd=4 is granted while port 1 stays valid, and `wb0_ready = 0`.
- x0 drop: `wb1` with rd=0, data=0x1234. `wr_en` stays 0, `wb1_ready` returns to 1 after one cycle, and `hz_rs1` stays 0 for `q_rs1 = 0`.
- Streaming: `wb0` valid for 4 consecutive cycles with rd 1..4 and `wb1` idle. `wb0_ready` stays 1 and the strobe shows rd 1..4 on consecutive cycles.
- Reset mid-flight: both buffers full and `wr_en = 1`, then `rst` asserted between edges. `wr_en` falls immediately, both readies rise, and no strobe appears after release until a new handshake.
- Saturation: with `CNT_W = 4`, hold a tie for 20 cycles. `contention_cnt` reads 15 and stays at 15.
